// File: rtl/resize_controller.sv
// rtl/resize_controller.sv - sequencing controller for the grayscale resizing coprocessor
//
// Walks the destination image in raster order, fetches 1 (zoom/decimation)
// or 4 (block average) source pixels per output pixel from a 1-cycle-latency
// source RAM into registered operands, and writes the core result to the
// destination RAM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         job request (sampled in IDLE) and operation select
//   busy, done, err     status: not-IDLE, end-of-job pulse, reserved-mode flag
//   src_addr            source RAM read address
//   src_rd_data         source RAM read data
//   p00..p11            registered operands to the resizing core
//   algorithm_select    core algorithm (01 block average, 00 pass-through)
//   core_pixel          core result
//   dst_addr, dst_wr_en, dst_wr_data  destination RAM write port

module resize_controller #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rd_data,
  output logic [7:0]        p00,
  output logic [7:0]        p01,
  output logic [7:0]        p10,
  output logic [7:0]        p11,
  output logic [1:0]        algorithm_select,
  input  logic [7:0]        core_pixel,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_wr_en,
  output logic [7:0]        dst_wr_data
);

  localparam logic [1:0] MODE_ZOOM = 2'b00;
  localparam logic [1:0] MODE_RSVD = 2'b01;
  localparam logic [1:0] MODE_AVG  = 2'b11;

  localparam logic [ADDR_W-1:0] SW      = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] ZOOM_W  = ADDR_W'(2 * SRC_W);
  localparam logic [ADDR_W-1:0] ZOOM_H  = ADDR_W'(2 * SRC_H);
  localparam logic [ADDR_W-1:0] SMALL_W = ADDR_W'(SRC_W / 2);
  localparam logic [ADDR_W-1:0] SMALL_H = ADDR_W'(SRC_H / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;
  logic [1:0]        k;

  logic [ADDR_W-1:0] dst_w;
  logic [ADDR_W-1:0] dst_h;
  logic [1:0]        k_last;
  logic              last_x;
  logic              last_y;
  logic [ADDR_W-1:0] next_dx;
  logic [ADDR_W-1:0] next_dy;

  // Source address for destination pixel (x, y) and read index kk. The 2x
  // downscale modes share one formula: decimation is the kk=0 average read,
  // and the kk bits simply fill the LSB freed by doubling the coordinates.
  function automatic logic [ADDR_W-1:0] src_addr_of(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] x,
    input logic [ADDR_W-1:0] y,
    input logic [1:0]        kk
  );
    logic [ADDR_W-1:0] sx;
    logic [ADDR_W-1:0] sy;
    if (m == MODE_ZOOM) begin
      sx = {1'b0, x[ADDR_W-1:1]};
      sy = {1'b0, y[ADDR_W-1:1]};
    end else begin
      sx = {x[ADDR_W-2:0], kk[0]};
      sy = {y[ADDR_W-2:0], kk[1]};
    end
    return sy * SW + sx;
  endfunction

  always_comb begin
    dst_w   = (mode_q == MODE_ZOOM) ? ZOOM_W : SMALL_W;
    dst_h   = (mode_q == MODE_ZOOM) ? ZOOM_H : SMALL_H;
    k_last  = (mode_q == MODE_AVG) ? 2'd3 : 2'd0;
    last_x  = (dx == dst_w - 1'b1);
    last_y  = (dy == dst_h - 1'b1);
    next_dx = last_x ? '0 : dx + 1'b1;
    next_dy = last_x ? dy + 1'b1 : dy;
  end

  // The core output is used directly; operands are frozen outside CAP.
  assign dst_wr_data = core_pixel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      mode_q           <= MODE_ZOOM;
      dx               <= '0;
      dy               <= '0;
      k                <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      src_addr         <= '0;
      dst_addr         <= '0;
      dst_wr_en        <= 1'b0;
      p00              <= '0;
      p01              <= '0;
      p10              <= '0;
      p11              <= '0;
      algorithm_select <= 2'b00;
    end else begin
      dst_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q           <= mode;
            dx               <= '0;
            dy               <= '0;
            k                <= '0;
            busy             <= 1'b1;
            src_addr         <= '0;
            algorithm_select <= (mode == MODE_AVG) ? 2'b01 : 2'b00;
            if (mode == MODE_RSVD) begin
              state <= S_DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= S_RD;
              err   <= 1'b0;
            end
          end
        end
        // Address is already on src_addr; this cycle is the RAM latency.
        S_RD: state <= S_CAP;
        S_CAP: begin
          case (k)
            2'd0:    p00 <= src_rd_data;
            2'd1:    p01 <= src_rd_data;
            2'd2:    p10 <= src_rd_data;
            default: p11 <= src_rd_data;
          endcase
          if (k != k_last) begin
            k        <= k + 2'd1;
            src_addr <= src_addr_of(mode_q, dx, dy, k + 2'd1);
            state    <= S_RD;
          end else begin
            dst_wr_en <= 1'b1;
            dst_addr  <= dy * dst_w + dx;
            state     <= S_WR;
          end
        end
        S_WR: begin
          k  <= '0;
          dx <= next_dx;
          dy <= next_dy;
          if (last_x && last_y) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            src_addr <= src_addr_of(mode_q, next_dx, next_dy, 2'd0);
            state    <= S_RD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resize_controller.sv
// tb/tb_resize_controller.sv - directed self-checking bench for resize_controller

module tb_resize_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 4x4 source (decimation / average / reserved / reset)
  logic       start_a = 1'b0;
  logic [1:0] mode_a = 2'b00;
  logic       busy_a, done_a, err_a, wr_en_a;
  logic [7:0] src_addr_a, dst_addr_a, rd_a, core_a, wr_data_a;
  logic [7:0] p00_a, p01_a, p10_a, p11_a;
  logic [1:0] alg_a;
  logic [7:0] mem_a [0:15];
  logic [9:0] sum_a;

  // Instance Z: 2x2 source (zoom)
  logic       start_z = 1'b0;
  logic [1:0] mode_z = 2'b00;
  logic       busy_z, done_z, err_z, wr_en_z;
  logic [7:0] src_addr_z, dst_addr_z, rd_z, core_z, wr_data_z;
  logic [7:0] p00_z, p01_z, p10_z, p11_z;
  logic [1:0] alg_z;
  logic [7:0] mem_z [0:3];
  logic [9:0] sum_z;

  resize_controller #(.SRC_W(4), .SRC_H(4), .ADDR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .src_addr(src_addr_a), .src_rd_data(rd_a),
    .p00(p00_a), .p01(p01_a), .p10(p10_a), .p11(p11_a),
    .algorithm_select(alg_a), .core_pixel(core_a),
    .dst_addr(dst_addr_a), .dst_wr_en(wr_en_a), .dst_wr_data(wr_data_a)
  );

  resize_controller #(.SRC_W(2), .SRC_H(2), .ADDR_W(8)) u_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .mode(mode_z),
    .busy(busy_z), .done(done_z), .err(err_z),
    .src_addr(src_addr_z), .src_rd_data(rd_z),
    .p00(p00_z), .p01(p01_z), .p10(p10_z), .p11(p11_z),
    .algorithm_select(alg_z), .core_pixel(core_z),
    .dst_addr(dst_addr_z), .dst_wr_en(wr_en_z), .dst_wr_data(wr_data_z)
  );

  // Source RAMs with one cycle read latency and a behavioural core
  always @(posedge clk) rd_a <= mem_a[src_addr_a[3:0]];
  always @(posedge clk) rd_z <= mem_z[src_addr_z[1:0]];
  assign sum_a  = {2'b00, p00_a} + {2'b00, p01_a} + {2'b00, p10_a} + {2'b00, p11_a};
  assign sum_z  = {2'b00, p00_z} + {2'b00, p01_z} + {2'b00, p10_z} + {2'b00, p11_z};
  assign core_a = (alg_a == 2'b01) ? sum_a[9:2] : p00_a;
  assign core_z = (alg_z == 2'b01) ? sum_z[9:2] : p00_z;

  // Destination write loggers
  int         wcnt_a = 0;
  int         wcnt_z = 0;
  logic [7:0] waddr_a [0:255];
  logic [7:0] wdata_a [0:255];
  logic [7:0] waddr_z [0:255];
  logic [7:0] wdata_z [0:255];

  always @(posedge clk) begin
    if (wr_en_a) begin
      waddr_a[wcnt_a[7:0]] <= dst_addr_a;
      wdata_a[wcnt_a[7:0]] <= wr_data_a;
      wcnt_a <= wcnt_a + 1;
    end
    if (wr_en_z) begin
      waddr_z[wcnt_z[7:0]] <= dst_addr_z;
      wdata_z[wcnt_z[7:0]] <= wr_data_z;
      wcnt_z <= wcnt_z + 1;
    end
  end

  // Drivers: return #1 after the accepting edge (i.e. in cycle 1)
  task automatic kick_a(input logic [1:0] m);
    @(negedge clk);
    mode_a  = m;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic kick_z(input logic [1:0] m);
    @(negedge clk);
    mode_z  = m;
    start_z = 1'b1;
    @(posedge clk);
    #1 start_z = 1'b0;
  endtask

  // Bounded wait; returns the cycle number in which done was seen (or 400)
  task automatic wait_done_a(input int c0, output int cyc);
    cyc = c0;
    while (!done_a && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic wait_done_z(input int c0, output int cyc);
    cyc = c0;
    while (!done_z && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset();
    int base;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, err_a, wr_en_a, alg_a, src_addr_a, dst_addr_a,
         p00_a, p01_a, p10_a, p11_a} !== '0) begin
      errors++;
      $display("FAIL reset_init outputs nonzero busy=%b src=%0d dst=%0d", busy_a, src_addr_a, dst_addr_a);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    kick_a(2'b11);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, err_a, wr_en_a, alg_a, src_addr_a, dst_addr_a,
         p00_a, p01_a, p10_a, p11_a} !== '0) begin
      errors++;
      $display("FAIL reset_async busy=%b alg=%0d src=%0d dst=%0d p01=%0d p10=%0d want all 0",
               busy_a, alg_a, src_addr_a, dst_addr_a, p01_a, p10_a);
    end
    base = wcnt_a;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (wcnt_a !== base || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_writes writes=%0d busy=%b want 0 0", wcnt_a - base, busy_a);
    end
  endtask

  task automatic test_decimation();
    int base, cyc;
    int exp_d [4] = '{0, 2, 8, 10};
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    base = wcnt_a;
    kick_a(2'b10);
    checks++;
    if (busy_a !== 1'b1 || alg_a !== 2'b00) begin
      errors++;
      $display("FAIL dec_cycle1 busy=%b alg=%0d want 1 0", busy_a, alg_a);
    end
    wait_done_a(1, cyc);
    checks++;
    if (cyc !== 13 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL dec_done_cycle cycle=%0d err=%b want 13 0", cyc, err_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL dec_busy_fall busy=%b done=%b want 0 0", busy_a, done_a);
    end
    checks++;
    if (wcnt_a - base !== 4) begin
      errors++;
      $display("FAIL dec_count writes=%0d want 4", wcnt_a - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (waddr_a[8'(base + i)] !== 8'(i) || wdata_a[8'(base + i)] !== 8'(exp_d[i])) begin
        errors++;
        $display("FAIL dec_wr%0d addr=%0d data=%0d want %0d %0d", i,
                 waddr_a[8'(base + i)], wdata_a[8'(base + i)], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_average();
    int base, cyc;
    int exp_v [4] = '{2, 4, 10, 12};
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    base = wcnt_a;
    kick_a(2'b11);
    checks++;
    if (alg_a !== 2'b01) begin
      errors++;
      $display("FAIL avg_alg alg=%0d want 1", alg_a);
    end
    wait_done_a(1, cyc);
    checks++;
    if (cyc !== 37) begin
      errors++;
      $display("FAIL avg_done_cycle cycle=%0d want 37", cyc);
    end
    checks++;
    if (wcnt_a - base !== 4) begin
      errors++;
      $display("FAIL avg_count writes=%0d want 4", wcnt_a - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (waddr_a[8'(base + i)] !== 8'(i) || wdata_a[8'(base + i)] !== 8'(exp_v[i])) begin
        errors++;
        $display("FAIL avg_wr%0d addr=%0d data=%0d want %0d %0d", i,
                 waddr_a[8'(base + i)], wdata_a[8'(base + i)], i, exp_v[i]);
      end
    end
    // Saturated source: sum 1020, core divides to 255
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) mem_a[i] = 8'd255;
    base = wcnt_a;
    kick_a(2'b11);
    wait_done_a(1, cyc);
    checks++;
    if (cyc !== 37 || wcnt_a - base !== 4) begin
      errors++;
      $display("FAIL avg255_timing cycle=%0d writes=%0d want 37 4", cyc, wcnt_a - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wdata_a[8'(base + i)] !== 8'd255) begin
        errors++;
        $display("FAIL avg255_wr%0d data=%0d want 255", i, wdata_a[8'(base + i)]);
      end
    end
  endtask

  task automatic test_zoom();
    int base, cyc;
    int exp_z [16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
    mem_z[0] = 8'd10;
    mem_z[1] = 8'd20;
    mem_z[2] = 8'd30;
    mem_z[3] = 8'd40;
    base = wcnt_z;
    kick_z(2'b00);
    wait_done_z(1, cyc);
    checks++;
    if (cyc !== 49 || err_z !== 1'b0) begin
      errors++;
      $display("FAIL zoom_done_cycle cycle=%0d err=%b want 49 0", cyc, err_z);
    end
    checks++;
    if (wcnt_z - base !== 16) begin
      errors++;
      $display("FAIL zoom_count writes=%0d want 16", wcnt_z - base);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (waddr_z[8'(base + i)] !== 8'(i) || wdata_z[8'(base + i)] !== 8'(exp_z[i])) begin
        errors++;
        $display("FAIL zoom_wr%0d addr=%0d data=%0d want %0d %0d", i,
                 waddr_z[8'(base + i)], wdata_z[8'(base + i)], i, exp_z[i]);
      end
    end
  endtask

  task automatic test_reserved();
    int base, cyc;
    base = wcnt_a;
    kick_a(2'b01);
    wait_done_a(1, cyc);
    checks++;
    if (cyc !== 1 || err_a !== 1'b1 || src_addr_a !== 8'd0) begin
      errors++;
      $display("FAIL rsvd_done cycle=%0d err=%b src=%0d want 1 1 0", cyc, err_a, src_addr_a);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wcnt_a !== base || busy_a !== 1'b0 || err_a !== 1'b1 || src_addr_a !== 8'd0) begin
      errors++;
      $display("FAIL rsvd_after writes=%0d busy=%b err=%b src=%0d want 0 0 1 0",
               wcnt_a - base, busy_a, err_a, src_addr_a);
    end
    kick_a(2'b10);
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_err_clear err=%b want 0", err_a);
    end
    wait_done_a(1, cyc);
    checks++;
    if (cyc !== 13 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_next_job cycle=%0d err=%b want 13 0", cyc, err_a);
    end
    @(posedge clk);
  endtask

  task automatic test_start_ignored();
    int base, cyc;
    int exp_d [4] = '{0, 2, 8, 10};
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    base = wcnt_a;
    kick_a(2'b10);
    @(negedge clk);
    mode_a  = 2'b11;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    checks++;
    if (alg_a !== 2'b00) begin
      errors++;
      $display("FAIL ign_alg alg=%0d want 0", alg_a);
    end
    wait_done_a(2, cyc);
    checks++;
    if (cyc !== 13 || wcnt_a - base !== 4) begin
      errors++;
      $display("FAIL ign_timing cycle=%0d writes=%0d want 13 4", cyc, wcnt_a - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (waddr_a[8'(base + i)] !== 8'(i) || wdata_a[8'(base + i)] !== 8'(exp_d[i])) begin
        errors++;
        $display("FAIL ign_wr%0d addr=%0d data=%0d want %0d %0d", i,
                 waddr_a[8'(base + i)], wdata_a[8'(base + i)], i, exp_d[i]);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_decimation();
    test_average();
    test_zoom();
    test_reserved();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
